// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 24-hour BCD HH:MM:SS counter with 1 Hz prescaler and set pulses
// Optional alarm output enabled by defining BCD_TIME_ALARM_EN.
module bcd_time_counter #(
   parameter int TICK_DIV = 50000000,
   parameter int PRESC_W  = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       inc_min,
   input  logic       inc_hr,
`ifdef BCD_TIME_ALARM_EN
   input  logic [3:0] alarm_hr_t,
   input  logic [3:0] alarm_hr_u,
   input  logic [3:0] alarm_min_t,
   input  logic [3:0] alarm_min_u,
   output logic       alarm_hit,
`endif
   output logic [3:0] hr_t,
   output logic [3:0] hr_u,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       sec_pulse
);

   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               set_any;

   // Per-digit wrap conditions; ">=" sends any non-BCD value back to 0.
   logic su_wrap, st_wrap, mu_wrap, mt_wrap, hu_wrap, hr_roll;
   logic min_roll, hr_carry;
   logic [3:0] su_inc, st_inc, mu_inc, mt_inc, hu_inc, ht_inc;
   // Next digit values for a tick and for a set pulse.
   logic [3:0] tk_su, tk_st, tk_mu, tk_mt, tk_hu, tk_ht;
   logic [3:0] st_mu, st_mt, st_hu, st_ht;

   assign tick    = en && (presc == PRESC_W'(TICK_DIV - 1));
   assign set_any = inc_min || inc_hr;

   // Incremented digit values and the cascaded next-time for a tick or a set pulse.
   always_comb begin
      su_wrap  = (sec_u >= 4'd9);
      st_wrap  = (sec_t >= 4'd5);
      mu_wrap  = (min_u >= 4'd9);
      mt_wrap  = (min_t >= 4'd5);
      hu_wrap  = (hr_u  >= 4'd9);
      hr_roll  = (hr_t  >= 4'd2) && (hr_u >= 4'd3);

      su_inc   = su_wrap ? 4'd0 : sec_u + 4'd1;
      st_inc   = st_wrap ? 4'd0 : sec_t + 4'd1;
      mu_inc   = mu_wrap ? 4'd0 : min_u + 4'd1;
      mt_inc   = mt_wrap ? 4'd0 : min_t + 4'd1;
      hu_inc   = (hr_roll || hu_wrap) ? 4'd0 : hr_u + 4'd1;
      if (hr_roll)
         ht_inc = 4'd0;
      else if (hu_wrap)
         ht_inc = (hr_t >= 4'd2) ? 4'd0 : hr_t + 4'd1;
      else
         ht_inc = hr_t;

      min_roll = su_wrap && st_wrap;
      hr_carry = min_roll && mu_wrap && mt_wrap;

      tk_su    = su_inc;
      tk_st    = su_wrap ? st_inc : sec_t;
      tk_mu    = min_roll ? mu_inc : min_u;
      tk_mt    = (min_roll && mu_wrap) ? mt_inc : min_t;
      tk_hu    = hr_carry ? hu_inc : hr_u;
      tk_ht    = hr_carry ? ht_inc : hr_t;

      st_mu    = inc_min ? mu_inc : min_u;
      st_mt    = (inc_min && mu_wrap) ? mt_inc : min_t;
      st_hu    = inc_hr ? hu_inc : hr_u;
      st_ht    = inc_hr ? ht_inc : hr_t;
   end

   // Time chain and prescaler: reset, then set pulses, then tick/enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         sec_pulse <= 1'b0;
         sec_u     <= 4'd0;
         sec_t     <= 4'd0;
         min_u     <= 4'd0;
         min_t     <= 4'd0;
         hr_u      <= 4'd0;
         hr_t      <= 4'd0;
      end else if (set_any) begin
         presc     <= '0;
         sec_pulse <= 1'b0;
         sec_u     <= 4'd0;
         sec_t     <= 4'd0;
         min_u     <= st_mu;
         min_t     <= st_mt;
         hr_u      <= st_hu;
         hr_t      <= st_ht;
      end else begin
         sec_pulse <= tick;
         if (tick) begin
            presc <= '0;
            sec_u <= tk_su;
            sec_t <= tk_st;
            min_u <= tk_mu;
            min_t <= tk_mt;
            hr_u  <= tk_hu;
            hr_t  <= tk_ht;
         end else if (en) begin
            presc <= presc + PRESC_W'(1);
         end
      end
   end

`ifdef BCD_TIME_ALARM_EN
   // Alarm is re-evaluated only when a tick rolls the minute, so it holds for 60 ticks.
   always_ff @(posedge clk) begin
      if (rst || set_any)
         alarm_hit <= 1'b0;
      else if (tick && min_roll)
         alarm_hit <= (tk_ht == alarm_hr_t) && (tk_hu == alarm_hr_u) &&
                      (tk_mt == alarm_min_t) && (tk_mu == alarm_min_u);
   end
`endif

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- 24-hour time-of-day counter that produces six BCD digits (HH:MM:SS) for the seven-segment decoding stage downstream.
- A prescaler divides the system clock to a 1 Hz tick. The tick advances a cascaded BCD seconds/minutes/hours chain.
- Single-cycle set pulses (already debounced upstream) adjust minutes and hours.
- Every digit output is a registered 4-bit BCD value in the range 0..9, directly consumable by the decoder.

Parameters:
- TICK_DIV, 50000000, system clock cycles per 1 s tick; must be >= 2.
- PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low freezes the prescaler and time chain.
- inc_min  input  1  one-cycle pulse; advance minutes by 1.
- inc_hr  input  1  one-cycle pulse; advance hours by 1.
- hr_t  output  4  hours tens digit, 0..2.
- hr_u  output  4  hours units digit, 0..9.
- min_t  output  4  minutes tens digit, 0..5.
- min_u  output  4  minutes units digit, 0..9.
- sec_t  output  4  seconds tens digit, 0..5.
- sec_u  output  4  seconds units digit, 0..9.
- sec_pulse  output  1  one-cycle strobe, high in the cycle the new seconds value appears.

Behaviour:
- Reset (rst high at a clock edge):
  - All digits go to 0 (00:00:00).
  - Prescaler goes to 0; sec_pulse goes to 0.
  - Reset overrides every other input, including mid-tick and mid-set.
- Prescaler:
  - When en = 1, it counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1) && en.
  - When en = 0, the prescaler holds its value and tick = 0.
- Tick handling (only when no inc pulse is present):
  - On the edge where tick = 1, sec_u increments.
  - Units 9 -> 0 carries into the tens digit. sec_t 5 -> 0 carries into min_u, and so on up the chain.
  - Hours roll over 23 -> 00: if hr_t == 2 and hr_u == 3, both digits clear.
  - sec_pulse is registered and high for exactly the one cycle after the tick edge, aligned with the updated digits. Digit latency is 1 clock from the tick.
- inc_min pulse:
  - Minutes += 1 mod 60 (59 -> 00) with no carry into hours.
  - sec_t and sec_u clear to 0 and the prescaler clears to 0.
- inc_hr pulse:
  - Hours += 1 mod 24 (23 -> 00).
  - Minutes are unaffected; seconds and the prescaler clear to 0.
- Set pulses are honoured regardless of en.
- Simultaneous events:
  - inc_min and inc_hr together: both apply in the same cycle, with no minute carry.
  - An inc pulse coincident with a tick: the inc takes priority, the tick is discarded and sec_pulse stays 0.
- No illegal state is reachable. Any non-BCD digit value (e.g. from an X-cleanup) wraps to 0 on its next increment.
- Widths: digits are 4-bit unsigned. Comparisons use constants 9, 5, 2 and 3.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN.
- When defined, the block adds:
  - Inputs alarm_hr_t, alarm_hr_u, alarm_min_t, alarm_min_u, each 4 bits.
  - Output alarm_hit, 1 bit.
- alarm_hit goes high (registered) in the cycle when all of the following hold: time equals alarm HH:MM, sec_t = 0, sec_u = 0, and the new time was produced by a tick.
- alarm_hit stays high for exactly 60 ticks, i.e. until the minute changes.
- Any inc pulse or rst clears alarm_hit to 0.
- When the macro is undefined, these ports and this logic are absent. All other behaviour is identical.

Test Plan:
- TICK_DIV=4, reset and then en=1 for 16 cycles -> time 00:00:04. sec_pulse is high 4 times, each on the cycle following prescaler==3.
- Preload via inc pulses to 23:59, run to 23:59:59, then one more tick -> 00:00:00 with a single sec_pulse.
- At 00:59:30, pulse inc_min -> 00:00:00 (no hour carry) with the prescaler cleared. At 23:10, pulse inc_hr -> 00:10:00.
- Assert inc_min in the exact cycle tick=1 at 00:00:05 -> 00:01:00, sec_pulse stays 0, and the next tick occurs TICK_DIV cycles later.
- Set en=0 mid-count with the prescaler at 2 and hold 10 cycles -> digits and prescaler unchanged. Re-enable -> a tick occurs after 1 more cycle.
- Assert rst at 12:34:56 with inc_hr high in the same cycle -> 00:00:00 next cycle. With BCD_TIME_ALARM_EN and alarm 00:01, the tick into 00:01:00 raises alarm_hit, which falls at 00:02:00.
